// File: rtl/efb_wb_arbiter_pkg.sv
// Shared definitions for the EFB Wishbone arbiter: grant FSM encodings and
// the configuration-interface register addresses of the MachXO2 EFB.
package efb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [7:0] CFGCR   = 8'h70;
    localparam logic [7:0] CFGTXDR = 8'h71;
    localparam logic [7:0] CFGSR   = 8'h72;
    localparam logic [7:0] CFGRXDR = 8'h73;

endpackage

// File: rtl/efb_wb_arbiter_if.sv
// One 8-bit Wishbone link; `lock` holds an arbiter grant across a session.
interface efb_wb_if;

    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack;
    logic       err;
    logic       lock;

    modport master (
        output cyc, stb, we, adr, dat_o, lock,
        input  dat_i, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_o, lock,
        output dat_i, ack, err
    );

endinterface

// File: rtl/efb_wb_watchdog.sv
// Counts consecutive cycles of an unacknowledged strobe and pulses `expire`
// in the cycle the count reaches TIMEOUT.
module efb_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic pending,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    assign expire = pending && (count == LIMIT);

    // Restart after an abort so a retained grant gets a fresh budget.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (!pending || expire)
            count <= '0;
        else
            count <= count + W'(1);
    end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Two-master arbiter in front of the MachXO2 EFB Wishbone port. A grant is
// held while the owner keeps cyc or lock high, so multi-byte sessions stay intact.
module efb_wb_arbiter
    import efb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    efb_wb_if.slave  m0,
    efb_wb_if.slave  m1,
    efb_wb_if.master s,
    output logic     busy,
    output logic     timeout,
    output logic     err_seen
);

    arb_state_t state, state_nxt;
    logic       last;
    logic       req0, req1;
    logic       pending, expire;

    assign req0 = m0.cyc | m0.lock;
    assign req1 = m1.cyc | m1.lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            last     <= 1'b1;
            err_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && state_nxt == ARB_GRANT0)
                last <= 1'b0;
            else if (state == ARB_IDLE && state_nxt == ARB_GRANT1)
                last <= 1'b1;
            if (expire)
                err_seen <= 1'b1;
        end
    end

    // Grants always pass through IDLE, giving the EFB its turnaround cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? ARB_GRANT0 : ARB_GRANT1;
                else if (req0)
                    state_nxt = ARB_GRANT0;
                else if (req1)
                    state_nxt = ARB_GRANT1;
            end
            ARB_GRANT0: if (!req0) state_nxt = ARB_IDLE;
            ARB_GRANT1: if (!req1) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    assign pending = ((state == ARB_GRANT0 && m0.stb) ||
                      (state == ARB_GRANT1 && m1.stb)) && !s.ack;

    efb_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .pending (pending),
        .expire  (expire)
    );

    // An expiring strobe is withdrawn from the EFB and answered locally with err.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = 8'h00;
        s.dat_o = 8'h00;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        case (state)
            ARB_GRANT0: begin
                s.cyc   = m0.cyc & ~expire;
                s.stb   = m0.stb & ~expire;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.dat_o = m0.dat_o;
                m0.ack  = s.ack | expire;
                m0.err  = expire;
            end
            ARB_GRANT1: begin
                s.cyc   = m1.cyc & ~expire;
                s.stb   = m1.stb & ~expire;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.dat_o = m1.dat_o;
                m1.ack  = s.ack | expire;
                m1.err  = expire;
            end
            default: ;
        endcase
    end

    assign s.lock   = 1'b0;
    assign m0.dat_i = s.dat_i;
    assign m1.dat_i = s.dat_i;
    assign busy     = (state != ARB_IDLE);
    assign timeout  = expire;

endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Shares the MachXO2 EFB Wishbone slave port between two Wishbone masters: master 0 is normally the UFM streamer, master 1 a user/I2C/SPI/timer master. Grant is held across a whole multi-byte configuration-interface session, not just a single `cyc` cycle, because EFB command sequences drop `cyc` between bytes. A per-grant watchdog returns an error acknowledge if the EFB stops responding. The block sits between the masters and the EFB primitive.

## Interface
- `TIMEOUT`, 255: cycles a strobe may remain unacknowledged before a forced error acknowledge; legal range 1..65535.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we` in 1: master 0 Wishbone controls.
- `m0_adr` in 8; `m0_dat_o` in 8: master 0 address and write data.
- `m0_lock` in 1: master 0 session hold; keeps the grant while high, even with `cyc` low.
- `m0_dat_i` out 8: read data returned to master 0.
- `m0_ack`, `m0_err` out 1: master 0 acknowledge and error.
- `m1_*`: identical set for master 1.
- `s_cyc`, `s_stb`, `s_we` out 1: Wishbone controls to the EFB.
- `s_adr` out 8; `s_dat_o` out 8: address and write data to the EFB.
- `s_dat_i` in 8; `s_ack` in 1: EFB read data and acknowledge.
- `busy` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse on a watchdog abort.
- `err_seen` out 1: sticky watchdog flag, cleared only by `rst`.

## Operation
- Request: `reqN = mN_cyc | mN_lock`.
- States are IDLE, GRANT0 and GRANT1, with registered state.
- **IDLE**
  - With no request, stay in IDLE.
  - With one request, go to GRANT of that master.
  - With both requesting, grant the master not in `last`.
  - `last` updates on each grant.
  - Reset value of `last` is 1, so master 0 wins the first tie.
- **GRANTn**
  - If `mn_cyc=0` and `mn_lock=0`, go to IDLE next edge; otherwise stay.
  - The other master's requests are ignored while a grant is active.
- **Muxing** (combinational)
  - In GRANTn, `s_cyc`/`s_stb`/`s_we`/`s_adr`/`s_dat_o` follow master n.
  - In IDLE, all `s_*` outputs are 0.
  - `s_dat_i` is broadcast to both `mN_dat_i`.
  - `mn_ack = s_ack` only in GRANTn; otherwise 0.
- **Watchdog**
  - Counter width is clog2(TIMEOUT+1).
  - Pending condition: GRANTn & `mn_stb` & !`s_ack`. The counter increments while pending and clears otherwise.
  - When the counter equals `TIMEOUT` and the condition is still pending, in that cycle:
    - `mn_ack=1` and `mn_err=1`;
    - `s_cyc=0` and `s_stb=0`;
    - `timeout=1`;
    - counter cleared;
    - `err_seen` set at the next edge.
  - The grant is retained; the master decides whether to release it.
- `mN_err` is 0 in all other cases.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `last`=1, counter 0, `err_seen` 0. Consequently all `s_*` outputs, `mN_ack`, `mN_err`, `busy` and `timeout` are 0.
- Grant latency: a request first seen at edge k yields the grant at edge k+1. `s_cyc` is visible in cycle k+1 with no further delay.
- Ack passes combinationally from `s_ack` to `mn_ack`, in the same cycle.
- Release: at least one IDLE cycle with `s_cyc=0` always separates two grants. This is the turnaround the EFB requires.
- Simultaneous release and other request: IDLE for one cycle, then the other master is granted.
- A strobe raised in cycle 0 and never acked gets the forced ack in cycle `TIMEOUT`.
- `rst` mid-grant returns to IDLE next edge and drops `s_cyc` immediately after that edge. No ack is issued for the aborted cycle.
- `lock` asserted while IDLE and `cyc` low counts as a request; the grant is taken with no bus activity.

## Structure
- Shared package `efb_pkg`:
  - state encodings ARB_IDLE, ARB_GRANT0, ARB_GRANT1 (2-bit);
  - EFB address constants CFGCR=8'h70, CFGTXDR=8'h71, CFGSR=8'h72, CFGRXDR=8'h73.
- Sub-module `efb_wb_watchdog` holds the parameterised counter. Inputs are `clk`, `rst`, `pending`; output is a `expire` pulse. It is instantiated once.
- The grant FSM, `last` register and output muxes live in the top level.

## Test plan
- **Reset:** `rst` high for 2 cycles with `m0_cyc=1` -> all `s_*`=0, `busy`=0. Grant to m0 arrives 1 cycle after `rst` falls.
- **Tie:** `m0_cyc` and `m1_cyc` both rise in the same cycle after reset -> GRANT0 first. After m0 releases: one IDLE cycle, then GRANT1. A subsequent tie goes to m0.
- **Lock hold:** m0 issues 0x74 to `adr` 8'h71 with `lock=1`, drops `cyc` 3 cycles while `m1_cyc=1` -> `s_cyc`=0 but GRANT0 is retained and m1 gets no ack. After m0 `lock`=0, m1 is granted 2 cycles later.
- **Read pass-through:** m1 reads `adr` 8'h73, EFB acks with 8'hA5 after 3 cycles -> `m1_ack` in that cycle, `m1_dat_i`=8'hA5, `m0_ack`=0.
- **Watchdog:** `TIMEOUT`=8, m0 strobes and `s_ack` is held 0 -> in cycle 8 `m0_ack`=`m0_err`=`timeout`=1 and `s_stb`=0. `err_seen`=1 thereafter. An ack arriving at cycle 7 -> no error.
- **Reset mid-grant:** assert `rst` during GRANT1 with `stb` pending -> IDLE after the edge, no ack or err issued, `err_seen` cleared.
